// File: rtl/fc_dense_out_arbiter.sv
// -----------------------------------------------------------------------------
// fc_dense_out_arbiter
//
// Merges the result streams of two dense-layer filter cores into one shared
// output FIFO in strict neuron order 0,1,2,3,... Filter0 produces the even
// neurons and filter1 the odd neurons. Each lane has a small circular buffer
// that back-pressures its core early enough to absorb the core's registered
// read pipeline. A layer pass is started by a one-cycle start pulse and ends
// after NUM_OUT results have been written, followed by a one-cycle done pulse.
//
// Parameters
//   DWIDTH   result data width
//   DEPTH    entries per lane buffer (power of 2, >= 4)
//   NUM_OUT  results expected per pass (1..65535, odd allowed)
//
// Ports
//   clock_i      system clock
//   reset_i      synchronous active-high reset
//   start_i      one-cycle pulse, begins a pass (ignored unless idle)
//   in0_data_i   filter0 result          in0_valid_i  filter0 result valid
//   in0_stall_o  stop filter0 from issuing further reads
//   in1_data_i   filter1 result          in1_valid_i  filter1 result valid
//   in1_stall_o  stop filter1 from issuing further reads
//   ff_wdata_o   output FIFO write data  ff_wrreq_o   output FIFO write strobe
//   ff_full_i    output FIFO full
//   busy_o       high while a pass is running
//   done_o       one-cycle pulse after the last result of a pass is written
//   out_count_o  results written in the current / last pass
//   ovf_err_o    sticky: a lane result was dropped because its buffer was full
//
// Build option
//   FC_ARB_RELU_EN  when defined, a ReLU is fused at the output: negative heads
//                   (sign bit set) are written as zero. Counting and handshake
//                   are unaffected.
// -----------------------------------------------------------------------------
module fc_dense_out_arbiter #(
    parameter int DWIDTH  = 32,
    parameter int DEPTH   = 4,
    parameter int NUM_OUT = 64
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [DWIDTH-1:0] in0_data_i,
    input  logic              in0_valid_i,
    output logic              in0_stall_o,
    input  logic [DWIDTH-1:0] in1_data_i,
    input  logic              in1_valid_i,
    output logic              in1_stall_o,
    output logic [DWIDTH-1:0] ff_wdata_o,
    output logic              ff_wrreq_o,
    input  logic              ff_full_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       out_count_o,
    output logic              ovf_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    // Two free entries must remain when the core is told to stop, because the
    // core has up to two results already in flight in its read pipeline.
    localparam logic [CW-1:0] STALL_AT  = CW'(DEPTH - 2);
    localparam logic [15:0]   NUM_OUT_C = 16'(NUM_OUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic              sel_q, sel_d;          // lane owning the next neuron
    logic [15:0]       out_count_q, out_count_d;
    logic              ovf_q, ovf_d;

    logic [DWIDTH-1:0] mem_q    [2][DEPTH];
    logic [AW-1:0]     rd_ptr_q [2];
    logic [AW-1:0]     rd_ptr_d [2];
    logic [AW-1:0]     wr_ptr_q [2];
    logic [AW-1:0]     wr_ptr_d [2];
    logic [CW-1:0]     count_q  [2];
    logic [CW-1:0]     count_d  [2];

    // ------------------------------------------------------------------
    // Lane bookkeeping
    // ------------------------------------------------------------------
    logic [1:0]        valid;
    logic [1:0]        nonempty;
    logic [1:0]        pop;
    logic [1:0]        push;
    logic              overflow;
    logic              wr_en;
    logic [DWIDTH-1:0] in_data [2];
    logic [DWIDTH-1:0] head;
    logic [DWIDTH-1:0] lane_out;

    assign valid      = {in1_valid_i, in0_valid_i};
    assign in_data[0] = in0_data_i;
    assign in_data[1] = in1_data_i;
    assign nonempty   = {count_q[1] != '0, count_q[0] != '0};

    // Only the lane that owns the next neuron may write; the other lane waits
    // even when it holds data, which keeps the output in neuron order.
    assign wr_en = (state_q == ST_RUN) && nonempty[sel_q] && !ff_full_i;

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first, so no path through the block can leave it unassigned and
        // infer a latch.
        pop      = '0;
        push     = '0;
        overflow = 1'b0;
        for (int l = 0; l < 2; l++) begin
            pop[l]  = wr_en && (sel_q == 1'(l));
            // A full lane still accepts a push when it is popped the same cycle.
            push[l] = valid[l] && ((count_q[l] != DEPTH_C) || pop[l]);
            if (valid[l] && !push[l]) begin
                overflow = 1'b1;
            end
            rd_ptr_d[l] = rd_ptr_q[l] + AW'(pop[l]);
            wr_ptr_d[l] = wr_ptr_q[l] + AW'(push[l]);
            count_d[l]  = count_q[l] + CW'(push[l]) - CW'(pop[l]);
        end
    end

    assign head = mem_q[sel_q][rd_ptr_q[sel_q]];

`ifdef FC_ARB_RELU_EN
    assign lane_out = head[DWIDTH-1] ? '0 : head;
`else
    assign lane_out = head;
`endif

    // Masking on empty keeps the output at zero instead of exposing stale or
    // uninitialised buffer contents.
    assign ff_wdata_o  = nonempty[sel_q] ? lane_out : '0;
    assign ff_wrreq_o  = wr_en;
    assign in0_stall_o = (count_q[0] >= STALL_AT);
    assign in1_stall_o = (count_q[1] >= STALL_AT);

    // ------------------------------------------------------------------
    // Pass control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        out_count_d = out_count_q;
        ovf_d       = ovf_q | overflow;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d     = ST_RUN;
                    sel_d       = 1'b0;
                    out_count_d = '0;
                end
            end
            ST_RUN: begin
                if (wr_en) begin
                    sel_d = ~sel_q;
                    if (out_count_q != NUM_OUT_C) begin
                        out_count_d = out_count_q + 16'd1;
                    end
                    if (out_count_q == NUM_OUT_C - 16'd1) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy_o      = (state_q == ST_RUN);
    assign done_o      = (state_q == ST_DONE);
    assign out_count_o = out_count_q;
    assign ovf_err_o   = ovf_q;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before the clock edge.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            out_count_q <= '0;
            ovf_q       <= 1'b0;
            for (int l = 0; l < 2; l++) begin
                rd_ptr_q[l] <= '0;
                wr_ptr_q[l] <= '0;
                count_q[l]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            out_count_q <= out_count_d;
            ovf_q       <= ovf_d;
            for (int l = 0; l < 2; l++) begin
                rd_ptr_q[l] <= rd_ptr_d[l];
                wr_ptr_q[l] <= wr_ptr_d[l];
                count_q[l]  <= count_d[l];
            end
        end
    end

    // NOTE: the buffer storage has no reset; emptiness is tracked by the
    // counts, so clearing them is enough to flush the lanes and the storage
    // can map onto plain RAM/register cells without a reset network.
    always_ff @(posedge clock_i) begin
        for (int l = 0; l < 2; l++) begin
            if (push[l]) begin
                mem_q[l][wr_ptr_q[l]] <= in_data[l];
            end
        end
    end

endmodule

// File: tb/tb_fc_dense_out_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fc_dense_out_arbiter.
//
// Two instances share one set of inputs: instance 0 runs passes of 4 results,
// instance 1 passes of 3 results (odd count, last result from lane 0). A
// behavioural model keeps one queue per lane and derives the owning lane of
// the next result from the neuron index (index modulo 2). Every cycle all
// outputs of both instances are compared against the model, and directed
// scenarios add explicit checks against constant expected values.
// -----------------------------------------------------------------------------
module tb_fc_dense_out_arbiter;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    int num_out_m [2] = '{4, 3};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          start;
    logic          v0, v1;
    logic [DW-1:0] d0, d1;
    logic          full;

    logic [DW-1:0] wdata_w  [2];
    logic          wrreq_w  [2];
    logic          stall0_w [2];
    logic          stall1_w [2];
    logic          busy_w   [2];
    logic          done_w   [2];
    logic [15:0]   cnt_w    [2];
    logic          ovf_w    [2];

    fc_dense_out_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH), .NUM_OUT(4)) u_dut_a (
        .clock_i     (clk),
        .reset_i     (reset),
        .start_i     (start),
        .in0_data_i  (d0),
        .in0_valid_i (v0),
        .in0_stall_o (stall0_w[0]),
        .in1_data_i  (d1),
        .in1_valid_i (v1),
        .in1_stall_o (stall1_w[0]),
        .ff_wdata_o  (wdata_w[0]),
        .ff_wrreq_o  (wrreq_w[0]),
        .ff_full_i   (full),
        .busy_o      (busy_w[0]),
        .done_o      (done_w[0]),
        .out_count_o (cnt_w[0]),
        .ovf_err_o   (ovf_w[0])
    );

    fc_dense_out_arbiter #(.DWIDTH(DW), .DEPTH(DEPTH), .NUM_OUT(3)) u_dut_b (
        .clock_i     (clk),
        .reset_i     (reset),
        .start_i     (start),
        .in0_data_i  (d0),
        .in0_valid_i (v0),
        .in0_stall_o (stall0_w[1]),
        .in1_data_i  (d1),
        .in1_valid_i (v1),
        .in1_stall_o (stall1_w[1]),
        .ff_wdata_o  (wdata_w[1]),
        .ff_wrreq_o  (wrreq_w[1]),
        .ff_full_i   (full),
        .busy_o      (busy_w[1]),
        .done_o      (done_w[1]),
        .out_count_o (cnt_w[1]),
        .ovf_err_o   (ovf_w[1])
    );

    // Reference model: phase 0 = idle, 1 = running, 2 = done cycle.
    logic [DW-1:0] mq [2][2][$];
    int            phase [2];
    int            mcnt  [2];
    bit            movf  [2];

    logic [DW-1:0] wlog [2][$];
    int            done_seen [2];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef FC_ARB_RELU_EN
        return x[DW-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i][0].delete();
            mq[i][1].delete();
            phase[i] = 0;
            mcnt[i]  = 0;
            movf[i]  = 1'b0;
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 2; i++) begin
            wlog[i].delete();
            done_seen[i] = 0;
        end
    endtask

    // Called at posedge+1 right after inputs are driven: compares outputs,
    // advances the model by one clock, and returns at the next posedge+1.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            int lane;
            bit exp_wr;
            lane   = mcnt[i] % 2;
            exp_wr = (phase[i] == 1) && (mq[i][lane].size() > 0) && !full;
            check($sformatf("wrreq[%0d]", i), 32'(wrreq_w[i]), 32'(exp_wr));
            if (exp_wr) begin
                check($sformatf("wdata[%0d]", i), wdata_w[i], relu(mq[i][lane][0]));
            end
            check($sformatf("busy[%0d]", i),   32'(busy_w[i]),   32'(phase[i] == 1));
            check($sformatf("done[%0d]", i),   32'(done_w[i]),   32'(phase[i] == 2));
            check($sformatf("count[%0d]", i),  32'(cnt_w[i]),    32'(mcnt[i]));
            check($sformatf("ovf[%0d]", i),    32'(ovf_w[i]),    32'(movf[i]));
            check($sformatf("stall0[%0d]", i), 32'(stall0_w[i]), 32'(mq[i][0].size() >= DEPTH - 2));
            check($sformatf("stall1[%0d]", i), 32'(stall1_w[i]), 32'(mq[i][1].size() >= DEPTH - 2));
            if (wrreq_w[i]) wlog[i].push_back(wdata_w[i]);
            if (done_w[i])  done_seen[i]++;

            if (reset) begin
                mq[i][0].delete();
                mq[i][1].delete();
                phase[i] = 0;
                mcnt[i]  = 0;
                movf[i]  = 1'b0;
            end else begin
                if (exp_wr) void'(mq[i][lane].pop_front());
                if (v0) begin
                    if (mq[i][0].size() < DEPTH) mq[i][0].push_back(d0);
                    else movf[i] = 1'b1;
                end
                if (v1) begin
                    if (mq[i][1].size() < DEPTH) mq[i][1].push_back(d1);
                    else movf[i] = 1'b1;
                end
                case (phase[i])
                    0: if (start) begin
                        phase[i] = 1;
                        mcnt[i]  = 0;
                    end
                    1: if (exp_wr) begin
                        mcnt[i]++;
                        if (mcnt[i] == num_out_m[i]) phase[i] = 2;
                    end
                    default: phase[i] = 0;
                endcase
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        v0    = 1'b0;
        v1    = 1'b0;
        full  = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] neg_exp;
        reset = 1'b1;
        start = 1'b0;
        v0 = 1'b0; v1 = 1'b0;
        d0 = '0;   d1 = '0;
        full = 1'b0;
        model_reset();
        clear_logs();
        @(posedge clk);
        #1;
        tick();
        tick();

        // ---- reset state ----
        for (int i = 0; i < 2; i++) begin
            check("rst_wrreq",  32'(wrreq_w[i]),  32'd0);
            check("rst_wdata",  wdata_w[i],       32'd0);
            check("rst_busy",   32'(busy_w[i]),   32'd0);
            check("rst_done",   32'(done_w[i]),   32'd0);
            check("rst_count",  32'(cnt_w[i]),    32'd0);
            check("rst_ovf",    32'(ovf_w[i]),    32'd0);
            check("rst_stall0", 32'(stall0_w[i]), 32'd0);
            check("rst_stall1", 32'(stall1_w[i]), 32'd0);
        end
        reset = 1'b0;

        // ---- ordered merge, lane1 result arrives first ----
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        v1 = 1'b1; d1 = 32'd20; tick();
        v1 = 1'b0; v0 = 1'b1; d0 = 32'd10; tick();
        v0 = 1'b1; d0 = 32'd30; v1 = 1'b1; d1 = 32'd40; tick();
        idle_inputs();
        repeat (8) tick();
        check("t1_len_a", 32'(wlog[0].size()), 32'd4);
        check("t1_a0", wlog[0][0], 32'd10);
        check("t1_a1", wlog[0][1], 32'd20);
        check("t1_a2", wlog[0][2], 32'd30);
        check("t1_a3", wlog[0][3], 32'd40);
        check("t1_cnt_a", 32'(cnt_w[0]), 32'd4);
        check("t1_done_a", 32'(done_seen[0]), 32'd1);
        // odd pass length: lane0, lane1, lane0 then done
        check("t4_len_b", 32'(wlog[1].size()), 32'd3);
        check("t4_b0", wlog[1][0], 32'd10);
        check("t4_b1", wlog[1][1], 32'd20);
        check("t4_b2", wlog[1][2], 32'd30);
        check("t4_cnt_b", 32'(cnt_w[1]), 32'd3);
        check("t4_done_b", 32'(done_seen[1]), 32'd1);

        // ---- output FIFO full mid-pass, start during RUN ignored ----
        reset = 1'b1; tick(); reset = 1'b0;
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        v0 = 1'b1; d0 = 32'd100; v1 = 1'b1; d1 = 32'd200; tick();
        d0 = 32'd300; d1 = 32'd400; tick();
        v0 = 1'b0; v1 = 1'b0; full = 1'b1;
        tick(); tick();
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("t2_full_len_a", 32'(wlog[0].size()), 32'd1);
        check("t2_full_cnt_a", 32'(cnt_w[0]), 32'd1);
        check("t2_busy_a", 32'(busy_w[0]), 32'd1);
        full = 1'b0;
        repeat (8) tick();
        check("t2_len_a", 32'(wlog[0].size()), 32'd4);
        check("t2_a0", wlog[0][0], 32'd100);
        check("t2_a1", wlog[0][1], 32'd200);
        check("t2_a2", wlog[0][2], 32'd300);
        check("t2_a3", wlog[0][3], 32'd400);
        check("t2_len_b", 32'(wlog[1].size()), 32'd3);

        // ---- lane0 fills while idle: stall and overflow ----
        reset = 1'b1; tick(); reset = 1'b0;
        clear_logs();
        v0 = 1'b1; d0 = 32'd1; tick();
        check("t3_stall_c1", 32'(stall0_w[0]), 32'd0);
        d0 = 32'd2; tick();
        check("t3_stall_c2", 32'(stall0_w[0]), 32'd1);
        d0 = 32'd3; tick();
        d0 = 32'd4; tick();
        check("t3_ovf_pre", 32'(ovf_w[0]), 32'd0);
        d0 = 32'd5; tick();
        v0 = 1'b0;
        check("t3_ovf_a", 32'(ovf_w[0]), 32'd1);
        check("t3_ovf_b", 32'(ovf_w[1]), 32'd1);
        start = 1'b1; tick(); start = 1'b0;
        v1 = 1'b1;
        d1 = 32'd11; tick();
        d1 = 32'd12; tick();
        d1 = 32'd13; tick();
        d1 = 32'd14; tick();
        v1 = 1'b0;
        repeat (8) tick();
        check("t3_len_a", 32'(wlog[0].size()), 32'd4);
        check("t3_a0", wlog[0][0], 32'd1);
        check("t3_a1", wlog[0][1], 32'd11);
        check("t3_a2", wlog[0][2], 32'd2);
        check("t3_a3", wlog[0][3], 32'd12);
        check("t3_ovf_sticky", 32'(ovf_w[0]), 32'd1);

        // ---- reset mid-pass ----
        reset = 1'b1; tick(); reset = 1'b0;
        clear_logs();
        start = 1'b1; tick(); start = 1'b0;
        v0 = 1'b1; d0 = 32'd5; v1 = 1'b1; d1 = 32'd6; tick();
        d0 = 32'd7; d1 = 32'd8; tick();
        v0 = 1'b0; v1 = 1'b0; tick();
        check("t5_pre_len", 32'(wlog[0].size()), 32'd2);
        // the write offered in the reset cycle itself still completes
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("t5_wrreq",  32'(wrreq_w[i]),  32'd0);
            check("t5_wdata",  wdata_w[i],       32'd0);
            check("t5_busy",   32'(busy_w[i]),   32'd0);
            check("t5_done",   32'(done_w[i]),   32'd0);
            check("t5_count",  32'(cnt_w[i]),    32'd0);
            check("t5_ovf",    32'(ovf_w[i]),    32'd0);
            check("t5_stall0", 32'(stall0_w[i]), 32'd0);
            check("t5_stall1", 32'(stall1_w[i]), 32'd0);
        end
        start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        check("t5_flushed_len", 32'(wlog[0].size()), 32'd3);
        check("t5_busy_empty", 32'(busy_w[0]), 32'd1);

        // ---- negative result at the output ----
        reset = 1'b1; tick(); reset = 1'b0;
        clear_logs();
`ifdef FC_ARB_RELU_EN
        neg_exp = 32'h0000_0000;
`else
        neg_exp = 32'hFFFF_FFF0;
`endif
        start = 1'b1; tick(); start = 1'b0;
        v0 = 1'b1; d0 = 32'hFFFF_FFF0; v1 = 1'b1; d1 = 32'd5; tick();
        v0 = 1'b0; v1 = 1'b0;
        repeat (4) tick();
        check("t6_len", 32'(wlog[0].size()), 32'd2);
        check("t6_neg", wlog[0][0], neg_exp);
        check("t6_pos", wlog[0][1], 32'd5);

        // ---- randomized traffic against the model ----
        reset = 1'b1; tick(); reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(499) == 0);
            start = ($urandom_range(19) == 0);
            v0    = ($urandom_range(2) == 0);
            v1    = ($urandom_range(2) == 0);
            d0    = $urandom;
            d1    = $urandom;
            full  = ($urandom_range(3) == 0);
            tick();
        end
        reset = 1'b0;
        idle_inputs();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
